// File: rtl/scan_pkg.sv
// Shared types for the scan sequencer: FSM states, line count and the decoder select type.
package scan_pkg;

  localparam int unsigned LINES = 4;

  typedef logic [1:0] sel_t;

  typedef enum logic [1:0] {
    StIdle,
    StBlank,
    StActive
  } scan_state_e;

endpackage

// File: rtl/scan_sequencer_if.sv
// Control/decoder bundle between a scan controller (master) and scan_sequencer (slave).
interface scan_sequencer_if
  import scan_pkg::*;
#(
  parameter int unsigned DWELL_W = 8
) ();

  logic               start;
  logic               stop;
  logic [DWELL_W-1:0] dwell;
  logic [LINES-1:0]   mask;
  sel_t               a;
  logic               e;
  logic               busy;
  logic               wrap;

  modport master (
    output start, stop, dwell, mask,
    input  a, e, busy, wrap
  );

  modport slave (
    input  start, stop, dwell, mask,
    output a, e, busy, wrap
  );

endinterface

// File: rtl/scan_next_sel.sv
// Combinational round-robin search: next set mask bit strictly after i_cur, wrapping modulo LINES.
module scan_next_sel
  import scan_pkg::*;
(
  input  logic [LINES-1:0] i_mask,
  input  sel_t             i_cur,
  output sel_t             o_next,
  output logic             o_wrap,
  output logic             o_none
);

  sel_t w_next;
  sel_t w_idx;
  logic w_found;

  // Offsets 1..LINES; offset LINES revisits i_cur itself for single-bit masks.
  always_comb begin
    w_next  = i_cur;
    w_idx   = '0;
    w_found = 1'b0;
    for (int unsigned i = 1; i <= LINES; i++) begin
      w_idx = i_cur + sel_t'(i);
      if (!w_found && i_mask[w_idx]) begin
        w_next  = w_idx;
        w_found = 1'b1;
      end
    end
  end

  assign o_next = w_next;
  assign o_none = !w_found;
  assign o_wrap = w_found && (w_next <= i_cur);

endmodule

// File: rtl/scan_sequencer.sv
// Round-robin select/enable generator for a 2-to-4 decoder with programmable dwell.
// Optional blanking gap between lines is compiled in with `define SCAN_BLANK_EN.
module scan_sequencer
  import scan_pkg::*;
#(
  parameter int unsigned DWELL_W   = 8,
  parameter int unsigned BLANK_CYC = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  scan_sequencer_if.slave  bus
);

  scan_state_e        r_state, w_state_d;
  sel_t               r_a, w_a_d;
  logic               r_e, w_e_d;
  logic               r_busy, w_busy_d;
  logic               r_wrap, w_wrap_d;
  logic               r_stop, w_stop_d;
  logic [DWELL_W-1:0] r_cnt, w_cnt_d;

  sel_t w_cur;
  sel_t w_next;
  logic w_wrap;
  logic w_none;
  logic w_go;
  logic w_last;
  logic w_stop_any;

`ifdef SCAN_BLANK_EN
  localparam int unsigned BlankW = (BLANK_CYC > 1) ? $clog2(BLANK_CYC) : 1;
  localparam logic [BlankW-1:0] BlankLoad = BlankW'(BLANK_CYC - 1);
  localparam scan_state_e LineEntry = StBlank;

  logic [BlankW-1:0] r_blank, w_blank_d;
`else
  localparam scan_state_e LineEntry = StActive;

  logic w_unused_blank_cyc;
  assign w_unused_blank_cyc = ^BLANK_CYC;
`endif

  // In IDLE, searching from the top index yields the lowest set bit.
  assign w_cur      = (r_state == StIdle) ? sel_t'(LINES - 1) : r_a;
  assign w_go       = bus.start && !bus.stop && !w_none;
  assign w_last     = (r_state == StActive) && (r_cnt == '0);
  assign w_stop_any = r_stop || bus.stop;

  scan_next_sel u_next_sel (
    .i_mask (bus.mask),
    .i_cur  (w_cur),
    .o_next (w_next),
    .o_wrap (w_wrap),
    .o_none (w_none)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= StIdle;
      r_a     <= '0;
      r_e     <= 1'b0;
      r_busy  <= 1'b0;
      r_wrap  <= 1'b0;
      r_stop  <= 1'b0;
      r_cnt   <= '0;
`ifdef SCAN_BLANK_EN
      r_blank <= '0;
`endif
    end else begin
      r_state <= w_state_d;
      r_a     <= w_a_d;
      r_e     <= w_e_d;
      r_busy  <= w_busy_d;
      r_wrap  <= w_wrap_d;
      r_stop  <= w_stop_d;
      r_cnt   <= w_cnt_d;
`ifdef SCAN_BLANK_EN
      r_blank <= w_blank_d;
`endif
    end
  end

  always_comb begin
    w_state_d = r_state;
    case (r_state)
      StIdle: begin
        if (w_go) w_state_d = LineEntry;
      end
`ifdef SCAN_BLANK_EN
      StBlank: begin
        if (r_blank == '0) w_state_d = StActive;
      end
`endif
      StActive: begin
        if (w_last) w_state_d = (w_stop_any || w_none) ? StIdle : LineEntry;
      end
      default: w_state_d = StIdle;
    endcase
  end

  // Next register values; e and busy follow the next state so a and e move on the same edge.
  always_comb begin
    w_a_d     = r_a;
    w_wrap_d  = 1'b0;
    w_stop_d  = r_stop;
    w_cnt_d   = r_cnt;
    w_e_d     = (w_state_d == StActive);
    w_busy_d  = (w_state_d != StIdle);
`ifdef SCAN_BLANK_EN
    w_blank_d = r_blank;
`endif
    case (r_state)
      StIdle: begin
        w_stop_d = 1'b0;
        if (w_go) begin
          w_a_d = w_next;
`ifdef SCAN_BLANK_EN
          w_blank_d = BlankLoad;
`else
          w_cnt_d = bus.dwell;
`endif
        end
      end
`ifdef SCAN_BLANK_EN
      StBlank: begin
        w_stop_d = w_stop_any;
        if (r_blank == '0) begin
          w_cnt_d = bus.dwell;
        end else begin
          w_blank_d = r_blank - BlankW'(1);
        end
      end
`endif
      StActive: begin
        w_stop_d = w_stop_any;
        if (!w_last) begin
          w_cnt_d = r_cnt - DWELL_W'(1);
        end else if (w_state_d == StIdle) begin
          w_stop_d = 1'b0;
        end else begin
          w_a_d    = w_next;
          w_wrap_d = w_wrap;
`ifdef SCAN_BLANK_EN
          w_blank_d = BlankLoad;
`else
          w_cnt_d = bus.dwell;
`endif
        end
      end
      default: begin
        w_stop_d = 1'b0;
      end
    endcase
  end

  assign bus.a    = r_a;
  assign bus.e    = r_e;
  assign bus.busy = r_busy;
  assign bus.wrap = r_wrap;

endmodule

// File: tb/tb_scan_sequencer.sv
// Self-checking bench for scan_sequencer: table-driven scans plus stop/mask/start corner cases.
module tb_scan_sequencer;

`ifdef SCAN_BLANK_EN
  localparam int BLANK = 2;
`else
  localparam int BLANK = 0;
`endif

  typedef struct packed {
    logic [1:0] a;
    logic       e;
    logic       busy;
    logic       wrap;
  } obs_t;

  typedef struct packed {
    logic [3:0]      mask;
    logic [7:0]      dwell;
    logic [0:4][1:0] seq;
    logic [0:4]      wrp;
  } vec_t;

  localparam int NV = 7;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  scan_sequencer_if #(.DWELL_W(8)) bus ();

  scan_sequencer #(
    .DWELL_W   (8),
    .BLANK_CYC (2)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  obs_t exp_q[$];
  vec_t vecs[NV];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int t);
    obs_t exp_o;
    obs_t act_o;
    exp_o = exp_q.pop_front();
    act_o = '{a: bus.a, e: bus.e, busy: bus.busy, wrap: bus.wrap};
    n_vec++;
    if (act_o !== exp_o) begin
      n_err++;
      $display("FAIL %s t=%0d: got a=%0d e=%b busy=%b wrap=%b, want a=%0d e=%b busy=%b wrap=%b",
               name, t, act_o.a, act_o.e, act_o.busy, act_o.wrap,
               exp_o.a, exp_o.e, exp_o.busy, exp_o.wrap);
    end
  endtask

  task automatic push_line(input logic [1:0] a, input logic w, input int dwell);
    for (int i = 0; i < BLANK; i++)
      exp_q.push_back('{a: a, e: 1'b0, busy: 1'b1, wrap: (i == 0) && w});
    for (int i = 0; i <= dwell; i++)
      exp_q.push_back('{a: a, e: 1'b1, busy: 1'b1, wrap: (BLANK == 0) && (i == 0) && w});
  endtask

  task automatic push_idle(input logic [1:0] a, input int n);
    for (int i = 0; i < n; i++)
      exp_q.push_back('{a: a, e: 1'b0, busy: 1'b0, wrap: 1'b0});
  endtask

  task automatic reset_check(input string name);
    bus.start = 1'b0;
    bus.stop  = 1'b0;
    rst_n     = 1'b0;
    step();
    exp_q.push_back('0);
    check(name, 0);
    rst_n = 1'b1;
  endtask

  initial begin
    int t;
    int line_len;

    vecs[0] = '{mask: 4'b1111, dwell: 8'd3,
                seq: {2'd0, 2'd1, 2'd2, 2'd3, 2'd0}, wrp: 5'b00001};
    vecs[1] = '{mask: 4'b1010, dwell: 8'd2,
                seq: {2'd1, 2'd3, 2'd1, 2'd3, 2'd1}, wrp: 5'b00101};
    vecs[2] = '{mask: 4'b0100, dwell: 8'd1,
                seq: {2'd2, 2'd2, 2'd2, 2'd2, 2'd2}, wrp: 5'b01111};
    vecs[3] = '{mask: 4'b1111, dwell: 8'd0,
                seq: {2'd0, 2'd1, 2'd2, 2'd3, 2'd0}, wrp: 5'b00001};
    vecs[4] = '{mask: 4'b1111, dwell: 8'd1,
                seq: {2'd0, 2'd1, 2'd2, 2'd3, 2'd0}, wrp: 5'b00001};
    vecs[5] = '{mask: 4'b1001, dwell: 8'd1,
                seq: {2'd0, 2'd3, 2'd0, 2'd3, 2'd0}, wrp: 5'b00101};
    vecs[6] = '{mask: 4'b0110, dwell: 8'd5,
                seq: {2'd1, 2'd2, 2'd1, 2'd2, 2'd1}, wrp: 5'b00101};

    bus.start = 1'b0;
    bus.stop  = 1'b0;
    bus.dwell = '0;
    bus.mask  = '0;

    // Table-driven scans; each ends with a reset while a line is active.
    for (int v = 0; v < NV; v++) begin
      reset_check($sformatf("reset_v%0d", v));
      bus.mask  = vecs[v].mask;
      bus.dwell = vecs[v].dwell;
      bus.start = 1'b1;
      for (int j = 0; j < 5; j++)
        push_line(vecs[v].seq[j], vecs[v].wrp[j], int'(vecs[v].dwell));
      t = 0;
      while (exp_q.size() > 0) begin
        step();
        bus.start = 1'b0;
        check($sformatf("scan_v%0d", v), t);
        t++;
      end
    end
    reset_check("reset_mid_active");

    // start with empty mask, then start+stop together: both stay idle.
    bus.mask  = 4'b0000;
    bus.dwell = 8'd3;
    bus.start = 1'b1;
    push_idle(2'd0, 3);
    for (t = 0; t < 3; t++) begin
      step();
      check("start_mask0", t);
    end
    bus.mask = 4'b1111;
    bus.stop = 1'b1;
    push_idle(2'd0, 3);
    for (t = 0; t < 3; t++) begin
      step();
      check("start_and_stop", t);
    end
    bus.start = 1'b0;
    bus.stop  = 1'b0;

    // Stop during 2nd active cycle of line 1, with a stray start while busy on line 0.
    line_len = BLANK + 4;
    bus.mask  = 4'b1111;
    bus.dwell = 8'd3;
    bus.start = 1'b1;
    push_line(2'd0, 1'b0, 3);
    push_line(2'd1, 1'b0, 3);
    push_idle(2'd1, 3);
    t = 0;
    while (exp_q.size() > 0) begin
      step();
      bus.start = 1'b0;
      check("stop_seq", t);
      if (t == BLANK + 1) bus.start = 1'b1;
      if (t == line_len + BLANK + 1) bus.stop = 1'b1;
      if (t == line_len + BLANK + 2) bus.stop = 1'b0;
      t++;
    end

    // Restart from the lowest set bit of a new mask.
    bus.mask  = 4'b1100;
    bus.start = 1'b1;
    push_line(2'd2, 1'b0, 3);
    t = 0;
    while (exp_q.size() > 0) begin
      step();
      bus.start = 1'b0;
      check("restart", t);
      t++;
    end
    reset_check("reset_after_restart");

    // Single-line mask cleared mid-line: idle at line end, no wrap.
    bus.mask  = 4'b0010;
    bus.dwell = 8'd2;
    bus.start = 1'b1;
    push_line(2'd1, 1'b0, 2);
    push_idle(2'd1, 3);
    t = 0;
    while (exp_q.size() > 0) begin
      step();
      bus.start = 1'b0;
      check("mask_clear", t);
      if (t == BLANK + 1) bus.mask = 4'b0000;
      t++;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/scan_sequencer.md
# scan_sequencer

Registered select/enable generator that drives the 2-bit address and active-high enable of the 2-to-4 decoder directly downstream. It steps through the enabled decoder lines in round-robin order and holds each line active for a programmable dwell time. An optional blanking gap separates lines so that only one decoder output is ever asserted. Typical uses are display-digit scanning and time-multiplexed strobes.

## Interface
- DWELL_W, 8: width of the dwell count input.
- BLANK_CYC, 2: number of blanking cycles (e low) before each active line. Must be ≥1. Used only with SCAN_BLANK_EN.
- clk  in  1  rising-edge clock.
- rst_n  in  1  reset; synchronous and active-low.
- start  in  1  begin scanning. Sampled only in IDLE.
- stop  in  1  end scanning after the current active line finishes.
- dwell  in  DWELL_W  active cycles per line minus one. Latched at each line entry.
- mask  in  4  line enables. Bit i=1 means line i is included in the scan.
- a  out  2  decoder address (to decoder A).
- e  out  1  decoder enable (to decoder E).
- busy  out  1  high whenever the FSM is not in IDLE.
- wrap  out  1  one-cycle pulse when the scan returns to a lower-or-equal line index.

## Operation
- All outputs are registered. Reset values: a=2'b00, e=0, busy=0, wrap=0, state=IDLE. The dwell counter resets to 0.
- FSM states: IDLE, BLANK, ACTIVE.
- IDLE:
  - e=0. a holds its last value.
  - If start=1, stop=0, and mask≠0: a is set to the lowest set bit of mask, busy goes to 1, and the FSM moves to BLANK (or directly to ACTIVE without SCAN_BLANK_EN).
  - If start=1 and mask=0: the FSM stays in IDLE.
  - If start and stop are both high: stop wins and the FSM stays in IDLE.
- BLANK: e=0 for BLANK_CYC cycles, then the FSM moves to ACTIVE and latches dwell.
- ACTIVE:
  - e=1 for dwell+1 cycles. dwell=0 gives a one-cycle strobe. Maximum is 2^DWELL_W cycles.
  - On the last active cycle, the next line is the next set mask bit above a, wrapping modulo 4. Mask is sampled on that cycle.
  - If the next index ≤ current a, wrap pulses together with the a update. A single-bit mask therefore pulses wrap at the end of every line.
- stop:
  - A stop seen in any BLANK/ACTIVE cycle is remembered in a sticky flag.
  - When the current ACTIVE period ends, the FSM goes to IDLE: e=0, busy=0, and a holds.
  - A stop raised during BLANK still lets that line complete its ACTIVE period.
- Mask changes:
  - If mask=0 at the line-end sample, the FSM goes to IDLE as for stop, and wrap does not pulse.
  - If mask changes mid-line, there is no effect until the line-end sample.
- start while busy is ignored.
- Reset asserted mid-scan returns to reset values on the next edge. There is no partial completion.

## Timing
- start is sampled at edge k. After edge k: busy=1, a=first line.
  - With SCAN_BLANK_EN: e=1 after edge k+BLANK_CYC.
  - Without SCAN_BLANK_EN: e=1 after edge k.
- Line-to-line transition:
  - With SCAN_BLANK_EN: e falls on the same edge that a changes. e stays low for BLANK_CYC cycles.
  - Without SCAN_BLANK_EN: a changes while e stays high. Back-to-back lines have no gap.
- Stop latency: e falls and busy falls on the same edge, at the end of the current ACTIVE period.
- a and e always change on the same clock edge, so the decoder never sees a stale address combined with a fresh enable.

## Configuration
- SCAN_BLANK_EN defined: the BLANK state and its counter are compiled in. BLANK_CYC is honoured.
- SCAN_BLANK_EN undefined:
  - The BLANK state is removed and BLANK_CYC is ignored.
  - Transitions are IDLE→ACTIVE and ACTIVE→ACTIVE (next line).
  - The steady-state period is exactly the sum of (dwell+1) over the enabled lines.

## Structure
- The shared package scan_pkg holds:
  - the state enum (IDLE, BLANK, ACTIVE);
  - LINES=4;
  - the 2-bit select typedef.
- Sub-module scan_next_sel: a combinational find-next-set-bit with wrap. Inputs are mask and current index. Outputs are the next index, a wrap flag, and a none flag.
  - In IDLE it is used with current index 3 to obtain the lowest set bit.

## Test plan
- Reset behaviour: apply rst_n=0 mid-ACTIVE → after the next edge, a=00, e=0, busy=0, wrap=0.
- Full scan: mask=4'b1111, dwell=3, BLANK_CYC=2, pulse start → a sequence 0,1,2,3,0, each line with e high 4 cycles and low 2 cycles between lines. wrap pulses once at the 3→0 transition.
- Skip and single line:
  - mask=4'b1010 → a alternates 1,3, with wrap on each 3→1 transition.
  - mask=4'b0100 → a stays 2 and wrap pulses at the end of every line.
- Stop: assert stop during the 2nd active cycle of line 1 with dwell=3 → line 1 completes its 4 active cycles, then e=0, busy=0, and a stays 1. A new start restarts from the lowest mask bit.
- Corner cases:
  - dwell=0 gives a one-cycle e strobe per line.
  - start with mask=0 keeps busy=0.
  - start and stop high together keeps the FSM in IDLE.
  - start while busy causes no change.
  - mask cleared mid-line → IDLE at the line end with no wrap pulse.
- Build without SCAN_BLANK_EN, mask=4'b1111, dwell=1 → e stays continuously high and a advances every 2 cycles.
